// File: rtl/arb_lru_matrix_reg.sv
// arb_lru_matrix_reg: WIDTH-way valid/ready arbiter with a least-recently-granted priority matrix
// and a registered single-entry output slice. Define ARB_LRU_LOCK_EN for packet locking (v_last_s/last_m).
module arb_lru_matrix_reg #(
    parameter  int WIDTH     = 4,
    parameter  int PLD_WIDTH = 32,
    localparam int IDW       = $clog2(WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     v_vld_s,
    output logic [WIDTH-1:0]     v_rdy_s,
    input  logic [PLD_WIDTH-1:0] v_pld_s [WIDTH],
`ifdef ARB_LRU_LOCK_EN
    input  logic [WIDTH-1:0]     v_last_s,
    output logic                 last_m,
`endif
    output logic                 vld_m,
    input  logic                 rdy_m,
    output logic [PLD_WIDTH-1:0] pld_m,
    output logic [IDW-1:0]       gnt_id_m
);

    // prio[i][j] = 1 means channel j beats channel i
    logic [WIDTH-1:0]     prio [WIDTH];
    logic                 load_ok;
    logic [WIDTH-1:0]     gnt_arb;
    logic [WIDTH-1:0]     gnt;
    logic                 gnt_any;
    logic [IDW-1:0]       gnt_idx;
    logic [PLD_WIDTH-1:0] gnt_pld;
    logic                 prio_upd;
`ifdef ARB_LRU_LOCK_EN
    logic                 lock_act;
    logic [IDW-1:0]       lock_id;
    logic                 gnt_last;
`endif

    always_comb begin
        load_ok = ~vld_m | rdy_m;
        gnt_arb = '0;
        for (int i = 0; i < WIDTH; i++) begin
            gnt_arb[i] = v_vld_s[i] & ~|(v_vld_s & prio[i]);
        end
`ifdef ARB_LRU_LOCK_EN
        // A locked packet bypasses the matrix until its last beat
        gnt = {WIDTH{load_ok}} & (lock_act ? (v_vld_s & (WIDTH'(1) << lock_id)) : gnt_arb);
`else
        gnt = {WIDTH{load_ok}} & gnt_arb;
`endif
        gnt_any = |gnt;
        gnt_idx = '0;
        gnt_pld = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (gnt[i]) begin
                gnt_idx = gnt_idx | IDW'(i);
            end
            gnt_pld = gnt_pld | ({PLD_WIDTH{gnt[i]}} & v_pld_s[i]);
        end
`ifdef ARB_LRU_LOCK_EN
        gnt_last = |(gnt & v_last_s);
        prio_upd = gnt_any & gnt_last;
`else
        prio_upd = gnt_any;
`endif
    end

    assign v_rdy_s = gnt;

    // Granted channel drops to lowest priority; diagonal is never written and stays 0
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < WIDTH; i++) begin
                for (int j = 0; j < WIDTH; j++) begin
                    prio[i][j] <= 1'(j < i);
                end
            end
        end else if (prio_upd) begin
            for (int i = 0; i < WIDTH; i++) begin
                for (int j = 0; j < WIDTH; j++) begin
                    if (i != j) begin
                        if (gnt[i]) begin
                            prio[i][j] <= 1'b1;
                        end else if (gnt[j]) begin
                            prio[i][j] <= 1'b0;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_m    <= 1'b0;
            pld_m    <= '0;
            gnt_id_m <= '0;
        end else if (gnt_any) begin
            vld_m    <= 1'b1;
            pld_m    <= gnt_pld;
            gnt_id_m <= gnt_idx;
        end else if (rdy_m) begin
            vld_m    <= 1'b0;
        end
    end

`ifdef ARB_LRU_LOCK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            last_m   <= 1'b0;
            lock_act <= 1'b0;
            lock_id  <= '0;
        end else if (gnt_any) begin
            last_m   <= gnt_last;
            lock_act <= ~gnt_last;
            lock_id  <= gnt_idx;
        end
    end
`endif

endmodule

// File: tb/tb_arb_lru_matrix_reg.sv
// tb_arb_lru_matrix_reg: directed scoreboard bench for arb_lru_matrix_reg (WIDTH=4, PLD_WIDTH=32).
// Lock-mode vectors are compiled in when ARB_LRU_LOCK_EN is defined.
module tb_arb_lru_matrix_reg;

    logic        clk;
    logic        rst;
    logic [3:0]  v_vld_s;
    logic [3:0]  v_rdy_s;
    logic [31:0] v_pld_s [4];
    logic        vld_m;
    logic        rdy_m;
    logic [31:0] pld_m;
    logic [1:0]  gnt_id_m;
`ifdef ARB_LRU_LOCK_EN
    logic [3:0]  v_last_s;
    logic        last_m;
`endif

    typedef struct {
        int          id;
        logic [31:0] pld;
        logic        last;
    } exp_t;

    exp_t exp_q [$];
    int   compared;
    int   mismatched;
    int   phase;
    int   load_phase;
    logic anti_ok;

    arb_lru_matrix_reg #(.WIDTH(4), .PLD_WIDTH(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .v_vld_s  (v_vld_s),
        .v_rdy_s  (v_rdy_s),
        .v_pld_s  (v_pld_s),
`ifdef ARB_LRU_LOCK_EN
        .v_last_s (v_last_s),
        .last_m   (last_m),
`endif
        .vld_m    (vld_m),
        .rdy_m    (rdy_m),
        .pld_m    (pld_m),
        .gnt_id_m (gnt_id_m)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] pld_of(int ph, int ch);
        return {8'(ph), 16'hA55A, 8'(ch)};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One cycle of stimulus; exp_id >= 0 queues the beat this cycle must grant
    task automatic applyStimulus(input logic [3:0] vld, input logic rdy,
                                 input logic [3:0] last, input int exp_id);
        exp_t e;
        phase++;
        for (int i = 0; i < 4; i++) v_pld_s[i] = pld_of(phase, i);
        v_vld_s = vld;
        rdy_m   = rdy;
`ifdef ARB_LRU_LOCK_EN
        v_last_s = last;
`endif
        if (exp_id >= 0) begin
            e.id   = exp_id;
            e.pld  = pld_of(phase, exp_id);
            e.last = last[exp_id];
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic stallCycle(input int exp_id, input logic [31:0] exp_pld);
        phase++;
        for (int i = 0; i < 4; i++) v_pld_s[i] = pld_of(phase, i);
        v_vld_s = 4'b1111;
        rdy_m   = 1'b0;
        #2;
        checkOutput("stall_v_rdy_s", 32'(v_rdy_s), 32'h0);
        checkOutput("stall_vld_m", 32'(vld_m), 32'h1);
        checkOutput("stall_gnt_id_m", 32'(gnt_id_m), 32'(exp_id));
        checkOutput("stall_pld_m", pld_m, exp_pld);
        @(posedge clk);
        #1;
    endtask

    task automatic pulseReset();
        v_vld_s = 4'b0000;
        rdy_m   = 1'b0;
        rst     = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Monitor: structural checks every cycle, scoreboard pop on each output transfer
    always @(negedge clk) begin
        if (!rst) begin
            checkOutput("v_rdy_s_legal",
                        32'($onehot0(v_rdy_s) && ((v_rdy_s & ~v_vld_s) == 4'b0000)), 32'h1);
            anti_ok = 1'b1;
            for (int i = 0; i < 4; i++) begin
                for (int j = 0; j < 4; j++) begin
                    if (i == j) anti_ok &= (dut.prio[i][j] == 1'b0);
                    else        anti_ok &= (dut.prio[i][j] != dut.prio[j][i]);
                end
            end
            checkOutput("prio_antisymmetric", 32'(anti_ok), 32'h1);
            if (vld_m && rdy_m) begin
                checkOutput("beat_expected", 32'(exp_q.size() != 0), 32'h1);
                if (exp_q.size() != 0) begin
                    exp_t e;
                    e = exp_q.pop_front();
                    checkOutput("gnt_id_m", 32'(gnt_id_m), 32'(e.id));
                    checkOutput("pld_m", pld_m, e.pld);
`ifdef ARB_LRU_LOCK_EN
                    checkOutput("last_m", 32'(last_m), 32'(e.last));
`endif
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int seq_all [8]  = '{0, 1, 2, 3, 0, 1, 2, 3};
        int seq_odd [4]  = '{1, 3, 1, 3};
        int seq_add [4]  = '{0, 1, 3, 0};
        int seq_rel [3]  = '{1, 3, 0};
        int seq_lru [4]  = '{0, 1, 3, 2};
        compared   = 0;
        mismatched = 0;
        phase      = 0;
        rst        = 1'b1;
        v_vld_s    = 4'b0000;
        rdy_m      = 1'b0;
        for (int i = 0; i < 4; i++) v_pld_s[i] = 32'h0;
`ifdef ARB_LRU_LOCK_EN
        v_last_s   = 4'b1111;
`endif
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("reset_vld_m", 32'(vld_m), 32'h0);
        checkOutput("reset_gnt_id_m", 32'(gnt_id_m), 32'h0);
        checkOutput("reset_pld_m", pld_m, 32'h0);
`ifdef ARB_LRU_LOCK_EN
        checkOutput("reset_last_m", 32'(last_m), 32'h0);
`endif

        // All valid from reset: round robin in index order
        foreach (seq_all[k]) applyStimulus(4'b1111, 1'b1, 4'b1111, seq_all[k]);
        repeat (2) applyStimulus(4'b0000, 1'b1, 4'b1111, -1);

        // Channels 1 and 3 alternate, then channel 0 joins at the top
        foreach (seq_odd[k]) applyStimulus(4'b1010, 1'b1, 4'b1111, seq_odd[k]);
        foreach (seq_add[k]) applyStimulus(4'b1011, 1'b1, 4'b1111, seq_add[k]);
        repeat (2) applyStimulus(4'b0000, 1'b1, 4'b1111, -1);

        // Backpressure: channel 2 held for 5 cycles, then ordering resumes
        applyStimulus(4'b1111, 1'b1, 4'b1111, 2);
        load_phase = phase;
        repeat (5) stallCycle(2, pld_of(load_phase, 2));
        foreach (seq_rel[k]) applyStimulus(4'b1111, 1'b1, 4'b1111, seq_rel[k]);
        repeat (2) applyStimulus(4'b0000, 1'b1, 4'b1111, -1);

        // Reset while a beat sits in the slice discards it
        applyStimulus(4'b1111, 1'b0, 4'b1111, -1);
        applyStimulus(4'b0000, 1'b0, 4'b1111, -1);
        checkOutput("held_vld_m", 32'(vld_m), 32'h1);
        pulseReset();
        checkOutput("midrst_vld_m", 32'(vld_m), 32'h0);
        checkOutput("midrst_gnt_id_m", 32'(gnt_id_m), 32'h0);
        checkOutput("midrst_pld_m", pld_m, 32'h0);

        // Only channel 2 for 3 beats, then all valid
        repeat (3) applyStimulus(4'b0100, 1'b1, 4'b1111, 2);
        foreach (seq_lru[k]) applyStimulus(4'b1111, 1'b1, 4'b1111, seq_lru[k]);
        repeat (2) applyStimulus(4'b0000, 1'b1, 4'b1111, -1);

`ifdef ARB_LRU_LOCK_EN
        // Put channel 1 on top, then a 3-beat packet on 1 with 0 and 2 competing
        pulseReset();
        applyStimulus(4'b0001, 1'b1, 4'b1111, 0);
        applyStimulus(4'b0100, 1'b1, 4'b1111, 2);
        applyStimulus(4'b0111, 1'b1, 4'b1101, 1);
        applyStimulus(4'b0111, 1'b1, 4'b1101, 1);
        applyStimulus(4'b0111, 1'b1, 4'b1111, 1);
        applyStimulus(4'b0111, 1'b1, 4'b1111, 0);
        applyStimulus(4'b0111, 1'b1, 4'b1111, 2);
        repeat (2) applyStimulus(4'b0000, 1'b1, 4'b1111, -1);
`endif

        v_vld_s = 4'b0000;
        rdy_m   = 1'b1;
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(posedge clk);
        #1;
        checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
